// File: rtl/multdiv_ctrl_pkg.sv
// Shared types and defaults for the multiply/divide sequencer.
// Holds the state encoding, the timing defaults and the op-type constants.
package multdiv_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int MAX_CYCLES_DEFAULT = 40;
   localparam int MIN_WAIT_DEFAULT   = 2;
   localparam int COUNT_W            = 6;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/multdiv_wait_counter.sv
// Saturating WAIT-cycle counter with synchronous clear.
// Flags when the stale-ready window has passed and when the watchdog expires.
module multdiv_wait_counter
   import multdiv_ctrl_pkg::*;
#(
   parameter int MIN_WAIT   = MIN_WAIT_DEFAULT,
   parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic ge_min,
   output logic timeout
);

   logic [COUNT_W-1:0] count_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg != {COUNT_W{1'b1}})) begin
         count_reg <= count_reg + 6'd1;
      end
   end

   assign ge_min  = (count_reg >= 6'(MIN_WAIT));
   assign timeout = (count_reg >= 6'(MAX_CYCLES));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between execute and the shared iterative mult/div unit: latches
// operands, pulses start, waits (with watchdog) and hands the result to writeback.
module multdiv_ctrl
   import multdiv_ctrl_pkg::*;
#(
   parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT,
   parameter int MIN_WAIT   = MIN_WAIT_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        issue_valid,
   input  logic        issue_is_div,
   input  logic [31:0] issue_opA,
   input  logic [31:0] issue_opB,
   input  logic [4:0]  issue_rd,
   output logic        issue_ready,
   output logic        stall,
   output logic        busy,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   output logic        md_ctrl_MULT,
   output logic        md_ctrl_DIV,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_exception,
   input  logic        wb_ack
);

   state_t      state_reg;
   logic [31:0] op_a_reg;
   logic [31:0] op_b_reg;
   logic [4:0]  rd_reg;
   logic        mult_reg;
   logic        div_reg;
   logic        wb_valid_reg;
   logic [31:0] wb_data_reg;
   logic        wb_exc_reg;

   logic accept;
   logic ge_min;
   logic timeout;

   // A new op may enter from IDLE, or from DONE in the same cycle the old result is acked.
   assign accept = ~reset & ~flush & issue_valid &
                   ((state_reg == IDLE) | ((state_reg == DONE) & wb_ack));

   assign issue_ready  = accept;
   assign stall        = ~reset & issue_valid & ~accept;
   assign busy         = (state_reg != IDLE);
   assign md_operandA  = op_a_reg;
   assign md_operandB  = op_b_reg;
   assign md_ctrl_MULT = mult_reg;
   assign md_ctrl_DIV  = div_reg;
   assign wb_valid     = wb_valid_reg;
   assign wb_rd        = rd_reg;
   assign wb_data      = wb_data_reg;
   assign wb_exception = wb_exc_reg;

   multdiv_wait_counter #(
      .MIN_WAIT   (MIN_WAIT),
      .MAX_CYCLES (MAX_CYCLES)
   ) u_wait_counter (
      .clock   (clock),
      .reset   (reset),
      .clear   (state_reg == START),
      .enable  (state_reg == WAIT),
      .ge_min  (ge_min),
      .timeout (timeout)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         op_a_reg     <= '0;
         op_b_reg     <= '0;
         rd_reg       <= '0;
         mult_reg     <= 1'b0;
         div_reg      <= 1'b0;
         wb_valid_reg <= 1'b0;
         wb_data_reg  <= '0;
         wb_exc_reg   <= 1'b0;
      end else begin
         mult_reg <= 1'b0;
         div_reg  <= 1'b0;
         // The start pulse is registered so it lands exactly in the START cycle.
         if (accept) begin
            op_a_reg <= issue_opA;
            op_b_reg <= issue_opB;
            rd_reg   <= issue_rd;
            mult_reg <= (issue_is_div == OP_MUL);
            div_reg  <= (issue_is_div == OP_DIV);
         end
         if (flush) begin
            state_reg    <= IDLE;
            wb_valid_reg <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (accept) state_reg <= START;
               end
               START: begin
                  state_reg <= WAIT;
               end
               WAIT: begin
                  // Ready outranks the watchdog when both land together.
                  if (md_resultRDY && ge_min) begin
                     wb_data_reg  <= md_result;
                     wb_exc_reg   <= md_exception;
                     wb_valid_reg <= 1'b1;
                     state_reg    <= DONE;
                  end else if (timeout) begin
                     wb_data_reg  <= '0;
                     wb_exc_reg   <= 1'b1;
                     wb_valid_reg <= 1'b1;
                     state_reg    <= DONE;
                  end
               end
               DONE: begin
                  if (wb_ack) begin
                     wb_valid_reg <= 1'b0;
                     state_reg    <= accept ? START : IDLE;
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl with a behavioural mult/div unit stub.
// Stimulus pushes expectations; a monitor pops them when the DUT responds.
module tb_multdiv_ctrl;

   localparam int MAX_C = 40;
   localparam int MIN_W = 2;

   logic        clock = 1'b0;
   logic        reset, flush, issue_valid, issue_is_div;
   logic [31:0] issue_opA, issue_opB;
   logic [4:0]  issue_rd;
   logic        issue_ready, stall, busy;
   logic [31:0] md_operandA, md_operandB;
   logic        md_ctrl_MULT, md_ctrl_DIV;
   logic [31:0] md_result;
   logic        md_exception, md_resultRDY;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_exception, wb_ack;

   multdiv_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .issue_valid  (issue_valid),
      .issue_is_div (issue_is_div),
      .issue_opA    (issue_opA),
      .issue_opB    (issue_opB),
      .issue_rd     (issue_rd),
      .issue_ready  (issue_ready),
      .stall        (stall),
      .busy         (busy),
      .md_operandA  (md_operandA),
      .md_operandB  (md_operandB),
      .md_ctrl_MULT (md_ctrl_MULT),
      .md_ctrl_DIV  (md_ctrl_DIV),
      .md_result    (md_result),
      .md_exception (md_exception),
      .md_resultRDY (md_resultRDY),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .wb_exception (wb_exception),
      .wb_ack       (wb_ack)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          is_div;
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
   } pulse_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          exc;
      int          lat;
   } res_t;

   pulse_t pulse_q[$];
   res_t   res_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic flag(input string name, input string act, input string exp);
      checks++;
      failures++;
      $display("FAIL %s cycle=%0d actual=%s required=%s", name, cyc, act, exp);
   endtask

   // Reference: a ready inside [MIN_W, MAX_C] WAIT cycles is taken, anything else times out.
   function automatic res_t model(input logic [4:0] rd, input int lat,
                                  input logic [31:0] res, input bit exc);
      res_t r;
      r.rd = rd;
      if (lat >= MIN_W && lat <= MAX_C) begin
         r.data = res; r.exc = exc; r.lat = lat + 2;
      end else begin
         r.data = 32'h0; r.exc = 1'b1; r.lat = MAX_C + 2;
      end
      return r;
   endfunction

   // Unit stub: after a start pulse, raises ready for one cycle at WAIT count stub_lat.
   int          stub_lat = -1, stub_stale = -10, act_lat = -1, stub_cnt = 0;
   logic [31:0] stub_res = '0, act_res = '0;
   bit          stub_exc = 1'b0, act_exc = 1'b0, stub_on = 1'b0;

   always @(negedge clock) begin
      if (reset) begin
         stub_on = 1'b0;
         md_resultRDY = 1'b0;
         md_result = '0;
         md_exception = 1'b0;
      end else begin
         if (md_ctrl_MULT || md_ctrl_DIV) begin
            stub_on = 1'b1; stub_cnt = -1;
            act_lat = stub_lat; act_res = stub_res; act_exc = stub_exc;
         end else if (stub_on) begin
            stub_cnt++;
         end
         if (stub_on && stub_cnt == act_lat) begin
            md_resultRDY = 1'b1; md_result = act_res; md_exception = act_exc;
         end else if (stub_on && stub_cnt == stub_stale) begin
            md_resultRDY = 1'b1; md_result = $urandom; md_exception = 1'($urandom_range(0, 1));
         end else begin
            md_resultRDY = 1'b0; md_result = $urandom; md_exception = 1'($urandom_range(0, 1));
         end
         if (stub_cnt > 64) stub_on = 1'b0;
      end
   end

   // Monitor: samples late in each cycle, well clear of the rising edge.
   bit     have_cur = 1'b0, last_pulse = 1'b0, in_op = 1'b0;
   res_t   cur;
   pulse_t cp;
   int     pulse_cyc = 0;

   always @(negedge clock) begin
      #3;
      if (reset) begin
         have_cur = 1'b0; last_pulse = 1'b0; in_op = 1'b0;
      end else begin
         if (md_ctrl_MULT || md_ctrl_DIV) begin
            chk("pulse_one_cycle", {31'b0, last_pulse}, 32'd0);
            chk("pulse_not_both", {31'b0, md_ctrl_MULT & md_ctrl_DIV}, 32'd0);
            if (pulse_q.size() == 0) begin
               flag("pulse_expected", "pulse", "no_pulse");
            end else begin
               cp = pulse_q.pop_front();
               chk("pulse_mult", {31'b0, md_ctrl_MULT}, {31'b0, ~cp.is_div});
               chk("pulse_div", {31'b0, md_ctrl_DIV}, {31'b0, cp.is_div});
               chk("pulse_cycle", cyc, cp.cyc);
               pulse_cyc = cyc;
               in_op = 1'b1;
            end
         end
         last_pulse = md_ctrl_MULT | md_ctrl_DIV;
         if (in_op) begin
            chk("operandA_hold", md_operandA, cp.a);
            chk("operandB_hold", md_operandB, cp.b);
         end
         if (wb_valid) begin
            if (!have_cur) begin
               if (res_q.size() == 0) begin
                  flag("wb_valid_expected", "wb_valid=1", "wb_valid=0");
               end else begin
                  cur = res_q.pop_front();
                  chk("wb_rd", {27'b0, wb_rd}, {27'b0, cur.rd});
                  chk("wb_data", wb_data, cur.data);
                  chk("wb_exception", {31'b0, wb_exception}, {31'b0, cur.exc});
                  chk("wb_latency", cyc - pulse_cyc, cur.lat);
                  $display("txn rd=%0d data=%h exc=%0d latency=%0d",
                           wb_rd, wb_data, wb_exception, cyc - pulse_cyc);
               end
               have_cur = 1'b1;
            end else begin
               chk("wb_rd_hold", {27'b0, wb_rd}, {27'b0, cur.rd});
               chk("wb_data_hold", wb_data, cur.data);
            end
            if (wb_ack) have_cur = 1'b0;
         end
      end
   end

   // Drives a request from a falling edge; returns at the next falling edge with issue_valid low.
   task automatic issue(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input logic [31:0] res,
                        input bit exc, input bit want_result, input bit immediate);
      int n = 0;
      issue_valid = 1'b1; issue_is_div = is_div;
      issue_opA = a; issue_opB = b; issue_rd = rd;
      stub_lat = lat; stub_res = res; stub_exc = exc;
      #1;
      while (!issue_ready && n < 100) begin
         @(negedge clock); #1; n++;
      end
      if (!issue_ready) begin
         flag("accept_timeout", "not_accepted", "accepted");
      end else begin
         if (immediate) chk("accept_immediate", n, 0);
         pulse_q.push_back('{is_div, a, b, cyc + 1});
         if (want_result) res_q.push_back(model(rd, lat, res, exc));
      end
      @(negedge clock);
      issue_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      #1;
      while (!wb_valid && n < 200) begin
         @(negedge clock); #1; n++;
      end
      if (!wb_valid) flag("wb_valid_timeout", "wb_valid=0", "wb_valid=1");
   endtask

   task automatic finish_op(input int ack_delay);
      wait_valid();
      repeat (ack_delay) @(negedge clock);
      wb_ack = 1'b1;
      @(negedge clock);
      wb_ack = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_issue_ready"}, {31'b0, issue_ready}, 32'd0);
      chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, "_operandA"}, md_operandA, 32'd0);
      chk({tag, "_operandB"}, md_operandB, 32'd0);
      chk({tag, "_mult"}, {31'b0, md_ctrl_MULT}, 32'd0);
      chk({tag, "_div"}, {31'b0, md_ctrl_DIV}, 32'd0);
      chk({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd0);
      chk({tag, "_wb_rd"}, {27'b0, wb_rd}, 32'd0);
      chk({tag, "_wb_data"}, wb_data, 32'd0);
      chk({tag, "_wb_exception"}, {31'b0, wb_exception}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout cycle=%0d actual=running required=finished", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_is_div = 1'b0;
      issue_opA = '0; issue_opB = '0; issue_rd = '0; wb_ack = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      check_all_zero("reset");
      @(negedge clock);
      reset = 1'b0;

      // Multiply 7 * -3 with a second request held (and stalled) during the op.
      issue(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 33, 32'hFFFF_FFEB, 1'b0, 1'b1, 1'b1);
      issue_valid = 1'b1; issue_is_div = 1'b1; issue_opA = 32'h1234; issue_rd = 5'd9;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_held", {31'b0, stall}, 32'd1);
         chk("held_not_accepted", {31'b0, issue_ready}, 32'd0);
         @(negedge clock);
      end
      issue_valid = 1'b0;
      finish_op(2);

      // Divide 100 / 7, then divide by zero.
      issue(1'b1, 32'd100, 32'd7, 5'd6, 33, 32'd14, 1'b0, 1'b1, 1'b1);
      finish_op(0);
      issue(1'b1, 32'd55, 32'd0, 5'd7, 33, 32'd0, 1'b1, 1'b1, 1'b1);
      finish_op(1);

      // No ready at all, with a stale ready at count 0: watchdog fires.
      stub_stale = 0;
      issue(1'b0, 32'd3, 32'd4, 5'd8, -1, 32'd0, 1'b0, 1'b1, 1'b1);
      finish_op(0);
      stub_stale = -10;

      // Boundaries: earliest accepted ready, ready inside the guard, ready on the timeout cycle.
      issue(1'b0, 32'd11, 32'd12, 5'd10, MIN_W, 32'hCAFE_0001, 1'b0, 1'b1, 1'b1);
      finish_op(0);
      issue(1'b1, 32'd13, 32'd14, 5'd11, MIN_W - 1, 32'hCAFE_0002, 1'b0, 1'b1, 1'b1);
      finish_op(0);
      issue(1'b0, 32'd15, 32'd16, 5'd12, MAX_C, 32'hCAFE_0003, 1'b1, 1'b1, 1'b1);
      finish_op(0);

      // Flush at WAIT count 10; the unit's later ready must be ignored.
      issue(1'b1, 32'd500, 32'd3, 5'd13, 33, 32'd166, 1'b0, 1'b0, 1'b1);
      repeat (11) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      #1;
      chk("busy_after_flush", {31'b0, busy}, 32'd0);
      chk("no_wb_after_flush", {31'b0, wb_valid}, 32'd0);
      repeat (30) @(negedge clock);
      issue(1'b0, 32'd21, 32'd22, 5'd14, 10, 32'd462, 1'b0, 1'b1, 1'b1);
      finish_op(0);

      // Flush beats a simultaneous issue; the op is taken the next cycle.
      flush = 1'b1; issue_valid = 1'b1; issue_is_div = 1'b0; issue_opA = 32'd9;
      #1;
      chk("flush_blocks_issue", {31'b0, issue_ready}, 32'd0);
      @(negedge clock);
      flush = 1'b0;
      issue(1'b0, 32'd9, 32'd9, 5'd15, 5, 32'd81, 1'b0, 1'b1, 1'b1);
      finish_op(0);

      // Back-to-back: ack and new issue in the same DONE cycle.
      issue(1'b0, 32'd3, 32'd4, 5'd16, 5, 32'd12, 1'b0, 1'b1, 1'b1);
      wait_valid();
      wb_ack = 1'b1;
      issue(1'b1, 32'd50, 32'd5, 5'd17, 10, 32'd10, 1'b0, 1'b1, 1'b1);
      wb_ack = 1'b0;
      finish_op(0);

      // Randomized ops.
      for (int i = 0; i < 12; i++) begin
         int r;
         int lat;
         r = int'($urandom_range(0, 9));
         if (r == 0) lat = -1;
         else if (r == 1) lat = int'($urandom_range(0, 1));
         else lat = int'($urandom_range(MIN_W, MAX_C));
         stub_stale = ($urandom_range(0, 3) == 0) ? 0 : -10;
         issue(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
               lat, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
         finish_op(int'($urandom_range(0, 3)));
      end
      stub_stale = -10;

      // Reset in the middle of WAIT clears everything.
      issue(1'b1, 32'd77, 32'd7, 5'd18, 33, 32'd11, 1'b0, 1'b1, 1'b1);
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      #1;
      check_all_zero("mid_wait_reset");
      res_q.delete();
      pulse_q.delete();
      @(negedge clock);
      reset = 1'b0;
      issue(1'b0, 32'd6, 32'd7, 5'd19, 8, 32'd42, 1'b0, 1'b1, 1'b1);
      finish_op(0);

      repeat (3) @(negedge clock);
      chk("scoreboard_drained", res_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
